// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: reset PC, stage-boundary payload widths and layouts.
package cpu_pkg;

  localparam logic [31:0] PC_RESET = 32'hbfc00000;

  // Per-boundary payload widths
  localparam int unsigned IF_ID_W  = 32 + 32;               // inst + pc
  localparam int unsigned MEM_WB_W = 32 + 5 + 4 + 1 + 32;   // wdata + waddr + strb + wen + pc

  // MEM/WB payload, MSB first
  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  waddr;
    logic [3:0]  strb;
    logic        wen;
    logic [31:0] pc;
  } mem_wb_t;

  // Bubble payload: no write enable, full strobe, reset PC
  localparam mem_wb_t MEM_WB_RST = '{
    wdata: 32'h0,
    waddr: 5'h0,
    strb:  4'hf,
    wen:   1'b0,
    pc:    PC_RESET
  };

  // Flatten a MEM/WB payload for a pipe_stage_reg instance
  function automatic logic [MEM_WB_W-1:0] pack_mem_wb(input mem_wb_t p);
    return MEM_WB_W'(p);
  endfunction

  // Recover the MEM/WB payload from a pipe_stage_reg output
  function automatic mem_wb_t unpack_mem_wb(input logic [MEM_WB_W-1:0] v);
    return mem_wb_t'(v);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// Single pipeline entry: one payload register plus its valid bit.
module pipe_skid_entry #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RST_DATA     = {WIDTH{1'b0}},
  parameter bit               BUBBLE_CLEAR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  // Clear (entry becomes empty) wins over load; payload optionally returns to the bubble value
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= RST_DATA;
    end else if (clear) begin
      valid <= 1'b0;
      if (BUBBLE_CLEAR) q <= RST_DATA;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush and optional skid entry.
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RST_DATA     = {WIDTH{1'b0}},
  parameter bit               BUBBLE_CLEAR = 1'b1,
  parameter bit               SKID         = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic             main_clear;
  logic [WIDTH-1:0] main_d;
  logic             main_valid;
  logic [WIDTH-1:0] main_q;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_q;

  // Main entry: always the oldest beat and the one presented downstream
  pipe_skid_entry #(
    .WIDTH        (WIDTH),
    .RST_DATA     (RST_DATA),
    .BUBBLE_CLEAR (BUBBLE_CLEAR)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  if (SKID == 1'b0) begin : g_single
    // Combinational allowin: accept when empty or when the held beat leaves this cycle
    assign in_ready   = !main_valid | out_ready;
    assign main_d     = in_data;
    assign main_load  = in_fire & !flush;
    assign main_clear = flush | (out_fire & !in_fire);

  end else begin : g_skid
    logic             skid_load;
    logic             skid_clear;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_q;
    logic             main_drain;
    logic             in_ready_q;

    // Main can take a beat this edge when empty or draining
    assign main_drain = !main_valid | out_ready;

    // Refill main from skid when skid is occupied, else from upstream; flush suppresses both
    assign main_d     = skid_valid ? skid_q : in_data;
    assign main_load  = !flush & ((skid_valid & out_fire) | (!skid_valid & in_fire & main_drain));
    assign main_clear = flush | (out_fire & !main_load);

    // Skid catches a beat accepted while main is full and stalled
    assign skid_load  = !flush & in_fire & !main_drain;
    assign skid_clear = flush | (skid_valid & out_fire);

    pipe_skid_entry #(
      .WIDTH        (WIDTH),
      .RST_DATA     (RST_DATA),
      .BUBBLE_CLEAR (BUBBLE_CLEAR)
    ) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (in_data),
      .valid (skid_valid),
      .q     (skid_q)
    );

    // Registered allowin tracks the next skid occupancy, so it always equals !skid_valid
    always_ff @(posedge clk) begin
      if (rst)             in_ready_q <= 1'b1;
      else if (skid_clear) in_ready_q <= 1'b1;
      else if (skid_load)  in_ready_q <= 1'b0;
    end

    assign in_ready = in_ready_q;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: single-entry (u_a) and skid (u_b) instances with MEM/WB payload.
module tb_pipe_stage_reg;
  import cpu_pkg::*;

  localparam int unsigned W = 74;
  // wdata=0, waddr=0, strb=4'hf, wen=0, pc=bfc00000
  localparam logic [W-1:0] RST_EXP = 74'h0_0000_001E_BFC0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [W-1:0] a_in_data = '0;
  logic         a_in_ready, a_out_valid;
  logic [W-1:0] a_out_data;

  logic         b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [W-1:0] b_in_data = '0;
  logic         b_in_ready, b_out_valid;
  logic [W-1:0] b_out_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .RST_DATA(MEM_WB_RST), .BUBBLE_CLEAR(1'b1), .SKID(1'b0)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
  );

  pipe_stage_reg #(.WIDTH(W), .RST_DATA(MEM_WB_RST), .BUBBLE_CLEAR(1'b1), .SKID(1'b1)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_a_valid: got %b want 0", a_out_valid); end
    vectors++; if (a_out_data !== RST_EXP) begin miscompares++; $display("FAIL reset_a_data: got %h want %h", a_out_data, RST_EXP); end
    vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_a_ready: got %b want 1", a_in_ready); end
    vectors++; if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_b_valid: got %b want 0", b_out_valid); end
    vectors++; if (b_out_data !== RST_EXP) begin miscompares++; $display("FAIL reset_b_data: got %h want %h", b_out_data, RST_EXP); end
    vectors++; if (b_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_b_ready: got %b want 1", b_in_ready); end
  endtask

  task automatic test_stream();
    logic [W-1:0] beats [3];
    beats[0] = 74'h11; beats[1] = 74'h22; beats[2] = 74'h33;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    a_in_valid  = 1'b1; b_in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_data = beats[i];
      b_in_data = beats[i];
      step();
      vectors++; if (a_out_valid !== 1'b1 || a_out_data !== beats[i]) begin miscompares++; $display("FAIL stream_a_%0d: got v=%b d=%h want v=1 d=%h", i, a_out_valid, a_out_data, beats[i]); end
      vectors++; if (b_out_valid !== 1'b1 || b_out_data !== beats[i]) begin miscompares++; $display("FAIL stream_b_%0d: got v=%b d=%h want v=1 d=%h", i, b_out_valid, b_out_data, beats[i]); end
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    step();
    vectors++; if (a_out_valid !== 1'b0 || a_out_data !== RST_EXP) begin miscompares++; $display("FAIL stream_a_drain: got v=%b d=%h want v=0 d=%h", a_out_valid, a_out_data, RST_EXP); end
    vectors++; if (b_out_valid !== 1'b0 || b_out_data !== RST_EXP) begin miscompares++; $display("FAIL stream_b_drain: got v=%b d=%h want v=0 d=%h", b_out_valid, b_out_data, RST_EXP); end
  endtask

  task automatic test_stall_single();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 74'hA5;
    step();
    // 0xBB is offered throughout the stall and must not be taken
    a_in_data = 74'hBB;
    #1;
    vectors++; if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL stall1_ready: got %b want 0", a_in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (a_out_valid !== 1'b1 || a_out_data !== 74'hA5) begin miscompares++; $display("FAIL stall1_hold_%0d: got v=%b d=%h want v=1 d=a5", i, a_out_valid, a_out_data); end
      vectors++; if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL stall1_ready_%0d: got %b want 0", i, a_in_ready); end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    #1;
    vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL stall1_release_ready: got %b want 1", a_in_ready); end
    step();
    vectors++; if (a_out_valid !== 1'b0 || a_out_data !== RST_EXP) begin miscompares++; $display("FAIL stall1_once: got v=%b d=%h want v=0 d=%h", a_out_valid, a_out_data, RST_EXP); end
    step();
    vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL stall1_empty: got %b want 0", a_out_valid); end
  endtask

  task automatic test_stall_skid();
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 74'h01;
    step();
    vectors++; if (b_out_valid !== 1'b1 || b_out_data !== 74'h01 || b_in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_main: got v=%b d=%h r=%b want v=1 d=01 r=1", b_out_valid, b_out_data, b_in_ready); end
    b_in_data = 74'h02;
    step();
    vectors++; if (b_in_ready !== 1'b0 || b_out_data !== 74'h01) begin miscompares++; $display("FAIL skid_fill: got r=%b d=%h want r=0 d=01", b_in_ready, b_out_data); end
    // 0x03 is offered while skid is full and must never emerge
    b_in_data = 74'h03;
    step();
    vectors++; if (b_in_ready !== 1'b0 || b_out_data !== 74'h01 || b_out_valid !== 1'b1) begin miscompares++; $display("FAIL skid_hold: got v=%b d=%h r=%b want v=1 d=01 r=0", b_out_valid, b_out_data, b_in_ready); end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    step();
    vectors++; if (b_out_valid !== 1'b1 || b_out_data !== 74'h02 || b_in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_second: got v=%b d=%h r=%b want v=1 d=02 r=1", b_out_valid, b_out_data, b_in_ready); end
    step();
    vectors++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_empty: got v=%b r=%b want v=0 r=1", b_out_valid, b_in_ready); end
  endtask

  task automatic test_flush();
    // Skid instance: main=0x55, skid=0x66, flush while 0x77 offered
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 74'h55;
    step();
    b_in_data = 74'h66;
    step();
    b_in_data = 74'h77;
    b_flush   = 1'b1;
    step();
    b_flush = 1'b0; b_in_valid = 1'b0;
    #1;
    vectors++; if (b_out_valid !== 1'b0 || b_out_data !== RST_EXP || b_in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_b_full: got v=%b d=%h r=%b want v=0 d=%h r=1", b_out_valid, b_out_data, b_in_ready, RST_EXP); end
    // Skid instance: beat 0x77 actually accepted in the flush cycle
    b_in_valid = 1'b1;
    b_in_data  = 74'h55;
    step();
    b_in_data = 74'h77;
    b_flush   = 1'b1;
    #1;
    vectors++; if (b_in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_b_accept: got %b want 1", b_in_ready); end
    step();
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    #1;
    vectors++; if (b_out_valid !== 1'b0 || b_out_data !== RST_EXP || b_in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_b_kill: got v=%b d=%h r=%b want v=0 d=%h r=1", b_out_valid, b_out_data, b_in_ready, RST_EXP); end
    step();
    vectors++; if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_b_after: got %b want 0", b_out_valid); end
    // Single instance: main=0x55 draining, 0x77 accepted under flush
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 74'h55;
    step();
    a_in_data = 74'h77;
    a_flush   = 1'b1;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    #1;
    vectors++; if (a_out_valid !== 1'b0 || a_out_data !== RST_EXP || a_in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_a: got v=%b d=%h r=%b want v=0 d=%h r=1", a_out_valid, a_out_data, a_in_ready, RST_EXP); end
    step();
    vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_a_after: got %b want 0", a_out_valid); end
  endtask

  task automatic test_rst_flush();
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    a_in_valid  = 1'b1; b_in_valid  = 1'b1;
    a_in_data   = 74'hC1; b_in_data = 74'hC1;
    step();
    a_in_data = 74'hC2; b_in_data = 74'hC2;
    step();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    rst = 1'b1; a_flush = 1'b1; b_flush = 1'b1;
    step();
    rst = 1'b0; a_flush = 1'b0; b_flush = 1'b0;
    #1;
    vectors++; if (a_out_valid !== 1'b0 || a_out_data !== RST_EXP || a_in_ready !== 1'b1) begin miscompares++; $display("FAIL rstflush_a: got v=%b d=%h r=%b want v=0 d=%h r=1", a_out_valid, a_out_data, a_in_ready, RST_EXP); end
    vectors++; if (b_out_valid !== 1'b0 || b_out_data !== RST_EXP || b_in_ready !== 1'b1) begin miscompares++; $display("FAIL rstflush_b: got v=%b d=%h r=%b want v=0 d=%h r=1", b_out_valid, b_out_data, b_in_ready, RST_EXP); end
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin miscompares++; $display("FAIL rstflush_quiet_%0d: got a=%b b=%b want 0 0", i, a_out_valid, b_out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_single();
    test_stall_skid();
    test_flush();
    test_rst_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
